// File: rtl/demux_dispatch_pkg.sv
// rtl/demux_dispatch_pkg.sv - shared defaults and sizing helper for the dispatch block
// Purpose: default parameter values and a constant ceil-log2 used to size
//          pointers and the occupancy counter.
// Ports: none (package).
package demux_dispatch_pkg;

    localparam int DEF_S = 2;
    localparam int DEF_T = 1;
    localparam int DEF_D = 4;

    // Smallest r with 2**r >= value; used at elaboration only.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// rtl/dispatch_fifo.sv - D-entry word FIFO with occupancy count
// Purpose: register-based FIFO storage, wrapping read/write pointers and count.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, pop    qualified write / read strobes (caller never pushes when full
//                or pops when empty)
//   wdata        word to store
//   rdata        word at the read pointer (straight from storage flops)
//   count        words held, 0..D
//   full, empty  count == D, count == 0
module dispatch_fifo
    import demux_dispatch_pkg::*;
#(
    parameter int W = 3,
    parameter int D = 4,
    localparam int AW = clog2(D)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [D];
    logic [W-1:0]  mem_d [D];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    // D is a power of two, so the AW-bit pointers wrap modulo D on their own.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(D));
    assign empty = (count_q == '0);

endmodule

// File: rtl/demux_dispatch.sv
// rtl/demux_dispatch.sv - buffered (dest, data) feeder for a recursive demux
// Purpose: accepts words on a valid/ready stream, queues them, and presents
//          the head word as ctrl/data with a one-hot out_valid strobe. The
//          head retires only when its own channel's out_ready is high.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake (in_ready = not full)
//   in_dest, in_data     destination channel and payload of incoming word
//   ctrl, data           head destination and payload (0 when empty)
//   out_valid            one-hot on bit ctrl while non-empty, else 0
//   out_ready            per-channel consumer ready
//   count                words held, 0..D
module demux_dispatch
    import demux_dispatch_pkg::*;
#(
    parameter int S = DEF_S,
    parameter int T = DEF_T,
    parameter int D = DEF_D,
    localparam int N  = 2**S,
    localparam int AW = clog2(D)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [S-1:0]  in_dest,
    input  logic [T-1:0]  in_data,
    output logic [S-1:0]  ctrl,
    output logic [T-1:0]  data,
    output logic [N-1:0]  out_valid,
    input  logic [N-1:0]  out_ready,
    output logic [AW:0]   count
);

    logic [S+T-1:0] head;
    logic [S-1:0]   head_dest;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    // No pass-through when full: a pop in the same cycle frees space only
    // for the following cycle because in_ready depends on registered count.
    assign in_ready  = !full;
    assign push      = in_valid & in_ready;
    assign head_dest = head[S+T-1:T];
    // Only the addressed channel's ready matters; others are ignored.
    assign pop       = !empty & out_ready[head_dest];

    dispatch_fifo #(
        .W (S + T),
        .D (D)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({in_dest, in_data}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Outputs are forced to zero when empty so stale storage never shows.
    always_comb begin
        ctrl      = '0;
        data      = '0;
        out_valid = '0;
        if (!empty) begin
            ctrl                 = head_dest;
            data                 = head[T-1:0];
            out_valid[head_dest] = 1'b1;
        end
    end

endmodule

// File: tb/tb_demux_dispatch.sv
// tb/tb_demux_dispatch.sv - scoreboard bench for demux_dispatch (S=2, T=1, D=4)
module tb_demux_dispatch;

    typedef struct {
        logic [1:0] dest;
        logic       data;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_dest;
    logic       in_data;
    logic [1:0] ctrl;
    logic       data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [2:0] count;

    int n_chk  = 0;
    int n_fail = 0;

    word_t mq[$];   // reference FIFO contents
    word_t sb[$];   // expected retire order for the monitor

    demux_dispatch #(.S(2), .T(1), .D(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .ctrl      (ctrl),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every retire the DUT presents must match the next expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid != 4'b0 && (out_valid & out_ready) != 4'b0) begin
            if (sb.size() == 0) begin
                chk("mon_unexpected_retire", {ctrl, data}, 32'hFFFF);
            end else begin
                word_t w;
                w = sb.pop_front();
                chk("mon_ctrl", ctrl, w.dest);
                chk("mon_data", data, w.data);
                chk("mon_onehot", out_valid, 4'b0001 << w.dest);
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+2.
    task automatic step(input logic v, input logic [1:0] d, input logic x);
        word_t w;
        logic  ep, eu;
        in_valid = v;
        in_dest  = d;
        in_data  = x;
        #2;
        chk("count", count, mq.size());
        chk("in_ready", in_ready, (mq.size() < 4) ? 1 : 0);
        if (mq.size() != 0) begin
            chk("head_ctrl", ctrl, mq[0].dest);
            chk("head_data", data, mq[0].data);
            chk("head_valid", out_valid, 4'b0001 << mq[0].dest);
        end else begin
            chk("empty_outputs", {ctrl, data, out_valid}, 0);
        end
        ep = (mq.size() != 0) && out_ready[mq[0].dest];
        eu = v && (mq.size() < 4);
        @(posedge clk);
        if (ep) void'(mq.pop_front());
        if (eu) begin
            w.dest = d;
            w.data = x;
            mq.push_back(w);
            sb.push_back(w);
        end
        #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && mq.size() != 0; i++) begin
            out_ready = 4'b0001 << mq[0].dest;
            step(1'b0, 2'd0, 1'b0);
        end
        chk("drained", count, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_dest   = 2'd0;
        in_data   = 1'b0;
        out_ready = 4'b0000;
        #1;
        chk("rst_count", count, 0);
        chk("rst_outputs", {ctrl, data, out_valid}, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // 1: reset mid-stream
        out_ready = 4'b0000;
        step(1'b1, 2'd1, 1'b1);
        step(1'b1, 2'd2, 1'b0);
        step(1'b1, 2'd3, 1'b1);
        chk("t1_count_before", count, 3);
        rst_n = 1'b0;
        #1;
        chk("t1_count", count, 0);
        chk("t1_out_valid", out_valid, 4'b0000);
        chk("t1_ctrl_data", {ctrl, data}, 0);
        mq.delete();
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("t1_in_ready", in_ready, 1);
        @(posedge clk);
        #2;

        // 2: single word
        out_ready = 4'b1111;
        step(1'b1, 2'd2, 1'b1);
        chk("t2_ctrl", ctrl, 2);
        chk("t2_data", data, 1);
        chk("t2_valid", out_valid, 4'b0100);
        step(1'b0, 2'd0, 1'b0);
        chk("t2_valid_after", out_valid, 4'b0000);
        chk("t2_count_after", count, 0);

        // 3: sweep destinations back to back
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'(k), 1'b1);
            chk("t3_valid", out_valid, 4'b0001 << k);
            chk("t3_count", count, 1);
        end
        step(1'b0, 2'd0, 1'b0);
        chk("t3_empty", out_valid, 4'b0000);

        // 4: backpressure, fill beyond capacity
        out_ready = 4'b0000;
        step(1'b1, 2'd3, 1'b1);
        step(1'b1, 2'd1, 1'b0);
        step(1'b1, 2'd0, 1'b1);
        step(1'b1, 2'd2, 1'b1);
        step(1'b1, 2'd1, 1'b1);   // rejected: FIFO full
        chk("t4_count", count, 4);
        chk("t4_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0, 1'b0);
            chk("t4_head_stable", {ctrl, data, out_valid}, {2'd3, 1'b1, 4'b1000});
        end
        drain();

        // 5: full with push+pop, then pointer wrap under sustained push+pop
        out_ready = 4'b0000;
        step(1'b1, 2'd0, 1'b1);
        step(1'b1, 2'd1, 1'b0);
        step(1'b1, 2'd2, 1'b1);
        step(1'b1, 2'd3, 1'b0);
        chk("t5_full", count, 4);
        out_ready = 4'b0001;
        step(1'b1, 2'd2, 1'b0);   // pop only, word not taken
        chk("t5_after_pop", count, 3);
        out_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'(i + 1), 1'(i));
            chk("t5_steady", count, 3);
        end
        drain();

        // 6: non-addressed ready bits are ignored
        out_ready = 4'b0000;
        step(1'b1, 2'd1, 1'b1);
        out_ready = 4'b1101;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'd0, 1'b0);
        end
        chk("t6_held", count, 1);
        out_ready = 4'b0010;
        step(1'b0, 2'd0, 1'b0);
        chk("t6_popped", count, 0);

        step(1'b0, 2'd0, 1'b0);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
